// File: rtl/branch_resolve_unit_pkg.sv
// Shared CPU definitions: ALU opcode encoding, branch FSM states and
// the branch-condition helper used by the resolve unit.
package cpu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'b0000,
    SUB = 4'b0001,
    AND = 4'b0010,
    ORR = 4'b0011,
    LSL = 4'b0100,
    CMP = 4'b0101,
    SET = 4'b0110,
    LDR = 4'b0111,
    STR = 4'b1000,
    B   = 4'b1001,
    BEQ = 4'b1010,
    BGE = 4'b1011,
    NOP = 4'b1100
  } alu_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } br_state_t;

  // Conditions read the architectural (registered) flags, never the live ALU flags.
  function automatic logic branch_taken(alu_op_t op, logic z, logic n);
    logic taken;
    taken = 1'b0;
    case (op)
      B:       taken = 1'b1;
      BEQ:     taken = z;
      BGE:     taken = ~n;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_flush_ctrl.sv
// Flush sequencer: holds the pipeline squash for FLUSH_CYCLES unstalled
// cycles after a taken branch; busy blocks new branch evaluation meanwhile.
module flush_ctrl
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stall,
  output logic flush_active,
  output logic busy
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_t     state;
  br_state_t     state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A stalled cycle never advances the state or the counter.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (!stall) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx = FLUSH;
            cnt_nx   = CW'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (cnt == '0) state_nx = IDLE;
          else           cnt_nx   = cnt - CW'(1);
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    flush_active = (state == FLUSH);
    busy         = (state == FLUSH);
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves B/BEQ/BGE against the CMP-written flags, issues a registered PC
// redirect, drives the IF/ID and ID/EX flushes and counts taken branches.
module branch_resolve_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              valid_ex,
  input  logic [3:0]        op_ex,
  input  logic              zero_ex,
  input  logic              negative_ex,
  input  logic [DATA_W-1:0] target_ex,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] pc_target,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flag_z,
  output logic              flag_n,
  output logic [CNT_W-1:0]  taken_cnt
);

  alu_op_t op;
  logic    busy;
  logic    flush_active;
  logic    accept;
  logic    take;

  assign op = alu_op_t'(op_ex);

  // Ops arriving while a flush is in progress are wrong-path and never accepted.
  assign accept = valid_ex & ~stall & ~busy;
  assign take   = accept & branch_taken(op, flag_z, flag_n);

  flush_ctrl #(
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_flush_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (take),
    .stall        (stall),
    .flush_active (flush_active),
    .busy         (busy)
  );

  assign flush_if_id = flush_active;
  assign flush_id_ex = flush_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (accept && op == CMP) begin
      flag_z <= zero_ex;
      flag_n <= negative_ex;
    end
  end

  // The redirect pulse clears on the first unstalled edge after it was raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_redirect <= 1'b0;
      pc_target   <= '0;
      taken_cnt   <= '0;
    end else if (!stall) begin
      pc_redirect <= take;
      if (take) begin
        pc_target <= target_ex;
        if (taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table, hand
// sequences for stall/reset/saturation and random traffic against a model.
module tb_branch_resolve_unit;

  localparam int DATA_W       = 16;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 5;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_B   = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1010;
  localparam logic [3:0] OP_BGE = 4'b1011;
  localparam logic [3:0] OP_NOP = 4'b1100;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              valid_ex;
  logic [3:0]        op_ex;
  logic              zero_ex;
  logic              negative_ex;
  logic [DATA_W-1:0] target_ex;
  logic              pc_redirect;
  logic [DATA_W-1:0] pc_target;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              flag_z;
  logic              flag_n;
  logic [CNT_W-1:0]  taken_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: flush_left counts the remaining cycles the flushes stay high.
  logic              m_z, m_n, m_redir;
  logic [DATA_W-1:0] m_target;
  int                m_cnt;
  int                m_flush_left;
  int                unstalled_flush;

  typedef struct {
    logic              valid;
    logic              stall;
    logic [3:0]        op;
    logic              z;
    logic              n;
    logic [DATA_W-1:0] tgt;
    logic              e_redir;
    logic [DATA_W-1:0] e_tgt;
    logic              e_flush;
    logic              e_z;
    logic              e_n;
    int                e_cnt;
  } vec_t;

  vec_t vecs[19];

  branch_resolve_unit #(
    .DATA_W       (DATA_W),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .valid_ex    (valid_ex),
    .op_ex       (op_ex),
    .zero_ex     (zero_ex),
    .negative_ex (negative_ex),
    .target_ex   (target_ex),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .taken_cnt   (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_z = 1'b0; m_n = 1'b0; m_redir = 1'b0;
    m_target = '0; m_cnt = 0; m_flush_left = 0;
  endtask

  task automatic modelStep();
    if (!stall) begin
      if (m_flush_left > 0) begin
        m_flush_left--;
        m_redir = 1'b0;
      end else if (valid_ex) begin
        if (op_ex == OP_CMP) begin
          m_z = zero_ex;
          m_n = negative_ex;
        end else if (op_ex == OP_B || (op_ex == OP_BEQ && m_z) || (op_ex == OP_BGE && !m_n)) begin
          m_redir      = 1'b1;
          m_target     = target_ex;
          m_flush_left = FLUSH_CYCLES;
          if (m_cnt < CNT_MAX) m_cnt++;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic [3:0] op,
                               input logic z, input logic n, input logic [DATA_W-1:0] tgt);
    logic pre_flush;
    valid_ex = v; stall = s; op_ex = op; zero_ex = z; negative_ex = n; target_ex = tgt;
    pre_flush = flush_if_id;
    @(posedge clk);
    if (!rst_n) modelReset();
    else        modelStep();
    if (!s && pre_flush === 1'b1) unstalled_flush++;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check1({tag, ".pc_redirect"}, 32'(pc_redirect), 32'(m_redir));
    check1({tag, ".pc_target"},   32'(pc_target),   32'(m_target));
    check1({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(m_flush_left > 0));
    check1({tag, ".flush_id_ex"}, 32'(flush_id_ex), 32'(m_flush_left > 0));
    check1({tag, ".flag_z"},      32'(flag_z),      32'(m_z));
    check1({tag, ".flag_n"},      32'(flag_n),      32'(m_n));
    check1({tag, ".taken_cnt"},   32'(taken_cnt),   32'(m_cnt));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, OP_NOP, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int redir_seen;
    int guard;
    int pick;
    logic [3:0] rop;

    vecs[0]  = '{1'b1, 1'b0, OP_CMP, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b0, OP_BEQ, 1'b0, 1'b0, 16'h0040, 1'b1, 16'h0040, 1'b1, 1'b1, 1'b0, 1};
    vecs[2]  = '{1'b0, 1'b0, OP_NOP, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b1, 1'b1, 1'b0, 1};
    vecs[3]  = '{1'b0, 1'b0, OP_NOP, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 1'b1, 1'b0, 1};
    vecs[4]  = '{1'b1, 1'b0, OP_CMP, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b1, 1};
    vecs[5]  = '{1'b1, 1'b0, OP_BGE, 1'b0, 1'b0, 16'h0100, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b1, 1};
    vecs[6]  = '{1'b1, 1'b0, OP_BEQ, 1'b0, 1'b0, 16'h0200, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b1, 1};
    vecs[7]  = '{1'b1, 1'b0, OP_ADD, 1'b1, 1'b0, 16'h0300, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b1, 1};
    vecs[8]  = '{1'b1, 1'b0, OP_B,   1'b0, 1'b0, 16'h0020, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b1, 2};
    vecs[9]  = '{1'b1, 1'b0, OP_CMP, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0020, 1'b1, 1'b0, 1'b1, 2};
    vecs[10] = '{1'b1, 1'b0, OP_B,   1'b0, 1'b0, 16'h0500, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b1, 2};
    vecs[11] = '{1'b1, 1'b0, OP_CMP, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0, 2};
    vecs[12] = '{1'b1, 1'b0, OP_BGE, 1'b0, 1'b0, 16'h0060, 1'b1, 16'h0060, 1'b1, 1'b0, 1'b0, 3};
    vecs[13] = '{1'b0, 1'b1, OP_NOP, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0060, 1'b1, 1'b0, 1'b0, 3};
    vecs[14] = '{1'b0, 1'b1, OP_NOP, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0060, 1'b1, 1'b0, 1'b0, 3};
    vecs[15] = '{1'b0, 1'b0, OP_NOP, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0060, 1'b1, 1'b0, 1'b0, 3};
    vecs[16] = '{1'b0, 1'b0, OP_NOP, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0060, 1'b0, 1'b0, 1'b0, 3};
    vecs[17] = '{1'b1, 1'b1, OP_B,   1'b0, 1'b0, 16'h0700, 1'b0, 16'h0060, 1'b0, 1'b0, 1'b0, 3};
    vecs[18] = '{1'b1, 1'b0, OP_NOP, 1'b1, 1'b1, 16'h0800, 1'b0, 16'h0060, 1'b0, 1'b0, 1'b0, 3};

    rst_n = 1'b1; stall = 1'b0; valid_ex = 1'b0; op_ex = OP_NOP;
    zero_ex = 1'b0; negative_ex = 1'b0; target_ex = '0;
    unstalled_flush = 0;
    modelReset();

    // Asynchronous reset asserted between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check1("reset_async.pc_redirect", 32'(pc_redirect), 32'd0);
    check1("reset_async.pc_target",   32'(pc_target),   32'd0);
    check1("reset_async.flush_if_id", 32'(flush_if_id), 32'd0);
    check1("reset_async.flush_id_ex", 32'(flush_id_ex), 32'd0);
    check1("reset_async.flag_z",      32'(flag_z),      32'd0);
    check1("reset_async.flag_n",      32'(flag_n),      32'd0);
    check1("reset_async.taken_cnt",   32'(taken_cnt),   32'd0);
    idle(2);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].stall, vecs[i].op, vecs[i].z, vecs[i].n, vecs[i].tgt);
      check1($sformatf("vec%0d.pc_redirect", i), 32'(pc_redirect), 32'(vecs[i].e_redir));
      check1($sformatf("vec%0d.pc_target", i),   32'(pc_target),   32'(vecs[i].e_tgt));
      check1($sformatf("vec%0d.flush_if_id", i), 32'(flush_if_id), 32'(vecs[i].e_flush));
      check1($sformatf("vec%0d.flush_id_ex", i), 32'(flush_id_ex), 32'(vecs[i].e_flush));
      check1($sformatf("vec%0d.flag_z", i),      32'(flag_z),      32'(vecs[i].e_z));
      check1($sformatf("vec%0d.flag_n", i),      32'(flag_n),      32'(vecs[i].e_n));
      check1($sformatf("vec%0d.taken_cnt", i),   32'(taken_cnt),   32'(vecs[i].e_cnt));
    end

    // Taken branch stalled for three cycles right at the redirect.
    unstalled_flush = 0;
    redir_seen = 0;
    applyStimulus(1'b1, 1'b0, OP_B, 1'b0, 1'b0, 16'h0abc);
    checkOutput("stall_seq.take");
    if (pc_redirect === 1'b1) redir_seen++;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, OP_CMP, 1'b1, 1'b1, 16'h0123);
      checkOutput($sformatf("stall_seq.hold%0d", i));
      if (pc_redirect === 1'b1) redir_seen++;
    end
    guard = 0;
    while (flush_if_id !== 1'b0 && guard < 10) begin
      applyStimulus(1'b0, 1'b0, OP_NOP, 1'b0, 1'b0, '0);
      checkOutput("stall_seq.drain");
      if (pc_redirect === 1'b1) redir_seen++;
      guard++;
    end
    check1("stall_seq.flush_ends", 32'(flush_if_id), 32'd0);
    check1("stall_seq.redirect_cycles", 32'(redir_seen), 32'd4);
    check1("stall_seq.unstalled_flush", 32'(unstalled_flush), 32'(FLUSH_CYCLES));

    // Reset arriving mid-flush clears everything without waiting for a clock.
    applyStimulus(1'b1, 1'b0, OP_B, 1'b0, 1'b0, 16'h0bad);
    checkOutput("midflush.take");
    #3 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midflush.reset");
    idle(2);
    checkOutput("midflush.held");
    rst_n = 1'b1;
    idle(1);
    checkOutput("midflush.release");

    // Counter saturation: preload to all-ones minus one, then three more takes.
    for (int i = 0; i < CNT_MAX - 1; i++) begin
      applyStimulus(1'b1, 1'b0, OP_B, 1'b0, 1'b0, 16'(i));
      idle(FLUSH_CYCLES);
    end
    check1("sat.preload", 32'(taken_cnt), 32'(CNT_MAX - 1));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, OP_B, 1'b0, 1'b0, 16'h0f00);
      idle(FLUSH_CYCLES);
      check1($sformatf("sat.extra%0d", i), 32'(taken_cnt), 32'(CNT_MAX));
    end
    checkOutput("sat.final");

    // Random traffic checked every cycle against the model.
    for (int i = 0; i < 2000; i++) begin
      pick = $urandom_range(0, 7);
      case (pick)
        0, 1:    rop = OP_CMP;
        2:       rop = OP_B;
        3, 4:    rop = OP_BEQ;
        5:       rop = OP_BGE;
        6:       rop = OP_NOP;
        default: rop = 4'($urandom_range(0, 15));
      endcase
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), rop,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      checkOutput($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
